mapper_mem_fetch: RTL

//  Memory-side responder for mapper read requests: accepts ram_cs/addr from a slot

---
 rtl/msx_fetch_pkg.sv | 14 +
 rtl/mapper_fetch_cache.sv | 43 ++++
 rtl/mapper_mem_fetch.sv | 124 ++++++++++++
 3 files changed

// File: rtl/msx_fetch_pkg.sv
// Shared types and constants for the mapper memory fetch path.
package msx_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } fetch_state_t;

  localparam logic [7:0] UNMAPPED_DATA   = 8'hFF;
  localparam int         DEFAULT_ADDR_W  = 27;
  localparam int         DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/mapper_fetch_cache.sv
// Single-entry read cache {valid, addr, data} for mapper_mem_fetch.
// Only instantiated when MAPPER_FETCH_CACHE_EN is defined.
module mapper_fetch_cache
  import msx_fetch_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] lookup_addr,
  input  logic              flush,
  input  logic              invalidate,
  input  logic              fill,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [7:0]        fill_data,
  output logic              hit,
  output logic [7:0]        hit_data
);

  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data;

  // Invalidation takes priority over a fill in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (flush || invalidate) begin
      valid <= 1'b0;
    end else if (fill) begin
      valid <= 1'b1;
      addr  <= fill_addr;
      data  <= fill_data;
    end
  end

  // A flush arriving with a lookup forces a miss.
  assign hit      = valid && (addr == lookup_addr) && !flush;
  assign hit_data = data;

endmodule

// File: rtl/mapper_mem_fetch.sv
// Memory-side responder for slot mapper reads: one-byte fetch over req/ready with CPU wait.
// Optional single-entry read cache enabled by defining MAPPER_FETCH_CACHE_EN.
module mapper_mem_fetch
  import msx_fetch_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_rd,
  input  logic              ram_cs,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic              flush,
  output logic              cpu_wait,
  output logic [7:0]        cpu_data,
  output logic              data_valid,
  output logic              timeout,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             unmapped_rd;
  logic             abort;
  logic             cache_hit;
  logic [7:0]       cache_data;

  assign accept      = (state == IDLE) && cpu_req && cpu_rd && ram_cs;
  assign unmapped_rd = (state == IDLE) && cpu_req && cpu_rd && !ram_cs;
  assign abort       = (state == ISSUE) && !mem_ready && (cnt == CNT_LAST);
  assign cpu_wait    = accept || (state == ISSUE);

`ifdef MAPPER_FETCH_CACHE_EN
  mapper_fetch_cache #(
    .ADDR_W(ADDR_W)
  ) u_cache (
    .clk        (clk),
    .reset_n    (reset_n),
    .lookup_addr(ram_addr),
    .flush      (flush),
    .invalidate (abort),
    .fill       ((state == ISSUE) && mem_ready),
    .fill_addr  (mem_addr),
    .fill_data  (mem_rdata),
    .hit        (cache_hit),
    .hit_data   (cache_data)
  );
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign cache_hit    = 1'b0;
  assign cache_data   = UNMAPPED_DATA;
`endif

  // data_valid and timeout are high only while in DONE, so they are single-cycle pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      cpu_data   <= UNMAPPED_DATA;
      data_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mem_addr <= ram_addr;
            cnt      <= '0;
            if (cache_hit) begin
              cpu_data   <= cache_data;
              data_valid <= 1'b1;
              state      <= DONE;
            end else begin
              mem_req <= 1'b1;
              state   <= ISSUE;
            end
          end else if (unmapped_rd) begin
            cpu_data   <= UNMAPPED_DATA;
            data_valid <= 1'b1;
            state      <= DONE;
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            cpu_data   <= mem_rdata;
            mem_req    <= 1'b0;
            data_valid <= 1'b1;
            state      <= DONE;
          end else if (abort) begin
            cpu_data   <= UNMAPPED_DATA;
            mem_req    <= 1'b0;
            data_valid <= 1'b1;
            timeout    <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
